// File: rtl/seq_detect_ctrl.sv
`timescale 1ns/1ps
// seq_detect_ctrl
// Accepts parallel words over a valid/ready handshake, serializes each one
// MSB-first onto a one-bit stream, and runs a programmable overlapping
// pattern matcher on that stream with a saturating match counter.
//
// Handshake: a word transfers on a rising edge where in_valid & in_ready
// are both high. in_data must stay stable while in_valid is high. in_ready
// is high in IDLE and on the last bit of a word, so back-to-back words
// stream with no bubble.
//
// Ports
//   clk          rising-edge clock
//   reset        synchronous, active-high reset
//   cfg_we       configuration write strobe (honoured only when idle and
//                cfg_len is 1..PAT_MAX)
//   cfg_pattern  pattern bits, bit 0 = most recent stream bit
//   cfg_len      pattern length
//   clear_count  synchronous clear of match_count (wins over an increment)
//   in_valid     requester has a word
//   in_data      word to serialize, MSB first
//   in_ready     controller accepts a word this cycle
//   x_out        current serial bit
//   x_valid      x_out carries a stream bit
//   match        one-cycle pulse, one cycle after the completing bit
//   match_count  saturating match counter
//   busy         word in flight; this is the FSM state (1 = SHIFT)
module seq_detect_ctrl #(
  parameter int DATA_W  = 8,
  parameter int PAT_MAX = 8,
  parameter int CNT_W   = 8,
  localparam int LEN_W  = $clog2(PAT_MAX + 1),
  localparam int IDX_W  = (DATA_W > 1) ? $clog2(DATA_W) : 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cfg_we,
  input  logic [PAT_MAX-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               clear_count,
  input  logic               in_valid,
  input  logic [DATA_W-1:0]  in_data,
  output logic               in_ready,
  output logic               x_out,
  output logic               x_valid,
  output logic               match,
  output logic [CNT_W-1:0]   match_count,
  output logic               busy
);

  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

  state_t             state;
  state_t             state_next;

  logic [DATA_W-1:0]  shreg;
  logic [IDX_W-1:0]   bit_idx;
  logic [PAT_MAX-1:0] history;
  logic [LEN_W-1:0]   fill;
  logic [PAT_MAX-1:0] pattern;
  logic [LEN_W-1:0]   len;

  logic               accept;
  logic               last_bit;
  logic               cfg_ok;
  logic [PAT_MAX-1:0] hist_next;
  logic [LEN_W-1:0]   fill_next;
  logic [PAT_MAX-1:0] mask;
  logic               hit;

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (in_valid) state_next = SHIFT;
      SHIFT:   if (last_bit && !in_valid) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    in_ready = 1'b0;
    x_valid  = 1'b0;
    busy     = 1'b0;
    x_out    = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
      end
      SHIFT: begin
        in_ready = last_bit;
        x_valid  = 1'b1;
        busy     = 1'b1;
        x_out    = shreg[DATA_W-1];
      end
      default: begin
        in_ready = 1'b0;
      end
    endcase
  end

  assign last_bit = (bit_idx == '0);
  assign accept   = in_valid & in_ready;
  assign cfg_ok   = cfg_we && (state == IDLE) && (cfg_len != '0) &&
                    (cfg_len <= LEN_W'(PAT_MAX));

  // ---------------- serializer ----------------
  always_ff @(posedge clk) begin
    if (reset) begin
      shreg   <= '0;
      bit_idx <= '0;
    end else if (accept) begin
      shreg   <= in_data;
      bit_idx <= IDX_W'(DATA_W - 1);
    end else if (state == SHIFT) begin
      shreg <= shreg << 1;
      if (!last_bit) bit_idx <= bit_idx - IDX_W'(1);
    end
  end

  // ---------------- matcher ----------------
  // The compare looks at the history as it will be after this bit, so the
  // registered match pulse lands one cycle after the completing bit.
  assign hist_next = {history[PAT_MAX-2:0], x_out};
  assign fill_next = (fill == LEN_W'(PAT_MAX)) ? fill : fill + LEN_W'(1);

  always_comb begin
    mask = '0;
    for (int i = 0; i < PAT_MAX; i++) begin
      mask[i] = (i < int'(len));
    end
  end

  assign hit = (fill_next >= len) && ((hist_next & mask) == (pattern & mask));

  always_ff @(posedge clk) begin
    if (reset) begin
      history <= '0;
      fill    <= '0;
      match   <= 1'b0;
      pattern <= PAT_MAX'(8'b0010_1010);
      len     <= LEN_W'(6);
    end else if (cfg_ok) begin
      // New pattern starts from an empty history so no stale partial
      // match against the old stream can fire.
      pattern <= cfg_pattern;
      len     <= cfg_len;
      history <= '0;
      fill    <= '0;
      match   <= 1'b0;
    end else if (x_valid) begin
      history <= hist_next;
      fill    <= fill_next;
      match   <= hit;
    end else begin
      match <= 1'b0;
    end
  end

  // ---------------- saturating counter ----------------
  always_ff @(posedge clk) begin
    if (reset) begin
      match_count <= '0;
    end else if (clear_count) begin
      match_count <= '0;
    end else if (match && (match_count != '1)) begin
      match_count <= match_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_seq_detect_ctrl.sv
`timescale 1ns/1ps
module tb_seq_detect_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       cfg_we;
  logic [7:0] cfg_pattern;
  logic [3:0] cfg_len;
  logic       clear_count;
  logic       in_valid;
  logic [7:0] in_data;

  logic       in_ready, x_out, x_valid, match, busy;
  logic [7:0] match_count;

  logic       in_ready2, x_out2, x_valid2, match2, busy2;
  logic [2:0] match_count2;

  int checks = 0;
  int errors = 0;

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  seq_detect_ctrl dut (
    .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_pattern(cfg_pattern),
    .cfg_len(cfg_len), .clear_count(clear_count), .in_valid(in_valid),
    .in_data(in_data), .in_ready(in_ready), .x_out(x_out), .x_valid(x_valid),
    .match(match), .match_count(match_count), .busy(busy)
  );

  // Narrow-counter instance sharing the same stimulus, used for saturation.
  seq_detect_ctrl #(.CNT_W(3)) dut_sat (
    .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_pattern(cfg_pattern),
    .cfg_len(cfg_len), .clear_count(clear_count), .in_valid(in_valid),
    .in_data(in_data), .in_ready(in_ready2), .x_out(x_out2), .x_valid(x_valid2),
    .match(match2), .match_count(match_count2), .busy(busy2)
  );

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "timeout");
  end

  // ---------------- driver helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Sends one word from IDLE and checks all 8 stream cycles plus the
  // trailing match cycle. mbits[k] = expected match after stream bit k.
  // cfg_at / clr_at pulse cfg_we / clear_count at that bit (8 = never).
  task automatic run_word(input string tag, input logic [7:0] d, input logic [7:0] mbits,
                          input int cfg_at, input int clr_at);
    in_valid = 1'b1;
    in_data  = d;
    tick();
    in_valid = 1'b0;
    for (int k = 0; k < 8; k++) begin
      check({tag, "_xvalid"}, x_valid, 1'b1);
      check({tag, "_busy"}, busy, 1'b1);
      check({tag, "_xout"}, x_out, d[7-k]);
      check({tag, "_ready"}, in_ready, (k == 7));
      check({tag, "_match"}, match, (k == 0) ? 1'b0 : mbits[k-1]);
      cfg_we      = (k == cfg_at);
      clear_count = (k == clr_at);
      tick();
    end
    cfg_we      = 1'b0;
    clear_count = 1'b0;
    check({tag, "_end_xvalid"}, x_valid, 1'b0);
    check({tag, "_end_busy"}, busy, 1'b0);
    check({tag, "_end_ready"}, in_ready, 1'b1);
    check({tag, "_end_match"}, match, mbits[7]);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset       = 1'b1;
    cfg_we      = 1'b0;
    cfg_pattern = 8'h00;
    cfg_len     = 4'd0;
    clear_count = 1'b0;
    in_valid    = 1'b0;
    in_data     = 8'h00;

    // Reset defaults
    tick();
    tick();
    check("rst_ready", in_ready, 1'b1);
    check("rst_xvalid", x_valid, 1'b0);
    check("rst_xout", x_out, 1'b0);
    check("rst_match", match, 1'b0);
    check("rst_count", match_count, 8'd0);
    check("rst_busy", busy, 1'b0);
    reset = 1'b0;
    tick();

    // Default pattern 101010, back-to-back 8'hAA 8'hAA
    in_valid = 1'b1;
    in_data  = 8'hAA;
    tick();
    for (int k = 0; k < 16; k++) begin
      check("b2b_xvalid", x_valid, 1'b1);
      check("b2b_busy", busy, 1'b1);
      check("b2b_xout", x_out, (k % 2 == 0));
      check("b2b_ready", in_ready, (k == 7) || (k == 15));
      check("b2b_match", match, (k >= 6) && (k % 2 == 0));
      if (k == 15) in_valid = 1'b0;
      tick();
    end
    check("b2b_last_match", match, 1'b1);
    check("b2b_idle", x_valid, 1'b0);
    tick();
    check("b2b_count", match_count, 8'd6);
    check("b2b_match_off", match, 1'b0);

    // Pattern 0110 on 8'h36: overlapping matches after bits 4 and 7
    cfg_pattern = 8'h06;
    cfg_len     = 4'd4;
    cfg_we      = 1'b1;
    clear_count = 1'b1;
    tick();
    cfg_we      = 1'b0;
    clear_count = 1'b0;
    check("p0110_cleared", match_count, 8'd0);
    run_word("p0110", 8'h36, 8'b1001_0000, 8, 8);
    tick();
    check("p0110_count", match_count, 8'd2);

    // cfg write while busy is ignored (would otherwise match every 1)
    cfg_pattern = 8'h01;
    cfg_len     = 4'd1;
    run_word("busy_cfg", 8'h36, 8'b1001_0000, 1, 8);
    tick();
    check("busy_cfg_count", match_count, 8'd4);

    // cfg_len = 0 in IDLE is ignored
    cfg_len = 4'd0;
    cfg_we  = 1'b1;
    tick();
    cfg_we = 1'b0;
    run_word("len0", 8'h36, 8'b1001_0000, 8, 8);
    tick();
    check("len0_count", match_count, 8'd6);

    // clear_count coincident with the bit-4 match pulse
    run_word("clr_coinc", 8'h36, 8'b1001_0000, 8, 5);
    tick();
    check("clr_coinc_count", match_count, 8'd1);

    // Saturation: pattern "1", 8'hFF -> 8 pulses, 3-bit counter sticks at 7
    cfg_pattern = 8'h01;
    cfg_len     = 4'd1;
    cfg_we      = 1'b1;
    clear_count = 1'b1;
    tick();
    cfg_we      = 1'b0;
    clear_count = 1'b0;
    check("sat_start", match_count2, 3'd0);
    run_word("sat1", 8'hFF, 8'hFF, 8, 8);
    tick();
    check("sat1_count8", match_count, 8'd8);
    check("sat1_count3", match_count2, 3'd7);
    run_word("sat2", 8'hFF, 8'hFF, 8, 8);
    tick();
    check("sat2_count8", match_count, 8'd16);
    check("sat2_count3", match_count2, 3'd7);

    // Reset during the 4th bit of 8'hAA
    in_valid = 1'b1;
    in_data  = 8'hAA;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    tick();
    check("midrst_bit3_xvalid", x_valid, 1'b1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("midrst_xvalid", x_valid, 1'b0);
    check("midrst_busy", busy, 1'b0);
    check("midrst_ready", in_ready, 1'b1);
    check("midrst_count", match_count, 8'd0);
    check("midrst_match", match, 1'b0);
    run_word("post_rst", 8'hAA, 8'b1010_0000, 8, 8);
    tick();
    check("post_rst_count", match_count, 8'd2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
